// File: rtl/npu_neuron_pe_pkg.sv
// npu_neuron_pe_pkg: FSM state encoding shared by the neuron processing element.
package npu_neuron_pe_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_BIAS, S_REQ, S_OUT_WAIT} state_t;
endpackage

// File: rtl/npu_mac_sat.sv
// npu_mac_sat: product / bias accumulate saturating at ACC_WIDTH, sticky overflow cleared on load.
module npu_mac_sat #(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_FRAC_BITS = 5,
  parameter int ACC_WIDTH     = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_add,
  input  logic                  i_bias,
  input  logic [DATA_WIDTH-1:0] i_weight,
  input  logic [DATA_WIDTH-1:0] i_act,
  input  logic [DATA_WIDTH-1:0] i_bias_val,
  output logic [ACC_WIDTH-1:0]  o_acc,
  output logic                  o_ovf
);
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0] w_addend, r_acc;
  logic signed [ACC_WIDTH:0] w_sum;
  logic w_sat, r_ovf;
  assign w_prod = $signed(i_weight) * $signed(i_act);
  // bias carries NUM_FRAC_BITS fractional bits, the accumulator twice that
  assign w_addend = i_bias ? ACC_WIDTH'($signed(i_bias_val)) <<< NUM_FRAC_BITS : ACC_WIDTH'(w_prod);
  assign w_sum = {w_addend[ACC_WIDTH-1], w_addend} + {r_acc[ACC_WIDTH-1], r_acc};
  assign w_sat = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
  assign o_acc = r_acc;
  assign o_ovf = r_ovf;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_load) begin
      r_acc <= w_addend;
      r_ovf <= 1'b0;
    end else if (i_add | i_bias) begin
      r_acc <= w_sat ? {w_sum[ACC_WIDTH], {(ACC_WIDTH-1){~w_sum[ACC_WIDTH]}}} : w_sum[ACC_WIDTH-1:0];
      r_ovf <= r_ovf | w_sat;
    end
endmodule

// File: rtl/npu_neuron_pe.sv
// npu_neuron_pe: neuron PE - saturating MAC, channel bias, requantise, ReLU, max-pool, valid/ready output.
// Build option NPU_NEURON_ROUND_EN: round half-up on requantise instead of truncating.
module npu_neuron_pe
  import npu_neuron_pe_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_FRAC_BITS = 5,
  parameter int ACC_WIDTH     = 20,
  parameter int POOL_SIZE     = 4,
  parameter int NUM_CH        = 32,
  parameter int ADDR_WIDTH    = 10,
  localparam int CH_W         = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mac_en,
  input  logic                  start_p,
  input  logic                  last_p,
  input  logic [DATA_WIDTH-1:0] weight_in,
  input  logic [DATA_WIDTH-1:0] act_in,
  input  logic                  relu_en,
  input  logic [CH_W-1:0]       ch_num,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  addr_clr,
  output logic [CH_W-1:0]       bias_rd_addr,
  input  logic [DATA_WIDTH-1:0] bias_rd_data,
  output logic                  acc_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  mac_overflow,
  output logic                  act_overflow,
  output logic                  protocol_err
);
  localparam int PW = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam logic signed [ACC_WIDTH:0] QMAX = (ACC_WIDTH+1)'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [ACC_WIDTH:0] QMIN = ~QMAX;
`ifdef NPU_NEURON_ROUND_EN
  localparam logic signed [ACC_WIDTH:0] RND = (ACC_WIDTH+1)'(1) << (NUM_FRAC_BITS - 1);
`else
  localparam logic signed [ACC_WIDTH:0] RND = '0;
`endif
  state_t r_state, w_next;
  logic w_acc_ready, w_load, w_add, w_clip, w_emit, w_hold, w_accept, w_load_out;
  logic signed [ACC_WIDTH-1:0] w_acc;
  logic signed [ACC_WIDTH:0] w_rnd, w_shr;
  logic signed [DATA_WIDTH-1:0] w_q, w_r, w_pool, r_pool_max, r_out_data;
  logic [PW-1:0] r_pool_cnt;
  logic [ADDR_WIDTH-1:0] r_base, r_idx, r_out_addr, w_base_nx, w_idx_nx;
  logic r_base_pend, r_out_valid, r_act_ovf, r_proto_err;
  assign w_load = mac_en & start_p & w_acc_ready;
  assign w_add = mac_en & ~start_p & (r_state == S_ACCUM);
  npu_mac_sat #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_FRAC_BITS(NUM_FRAC_BITS),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .i_load(w_load),
    .i_add(w_add),
    .i_bias(r_state == S_BIAS),
    .i_weight(weight_in),
    .i_act(act_in),
    .i_bias_val(bias_rd_data),
    .o_acc(w_acc),
    .o_ovf(mac_overflow)
  );
  assign w_rnd = {w_acc[ACC_WIDTH-1], w_acc} + RND;
  assign w_shr = w_rnd >>> NUM_FRAC_BITS;
  assign w_clip = (w_shr > QMAX) | (w_shr < QMIN);
  assign w_q = (w_shr > QMAX) ? DATA_WIDTH'(QMAX) : (w_shr < QMIN) ? DATA_WIDTH'(QMIN) : w_shr[DATA_WIDTH-1:0];
  assign w_r = (relu_en & w_q[DATA_WIDTH-1]) ? '0 : w_q;
  assign w_pool = (r_pool_cnt == '0 || w_r > r_pool_max) ? w_r : r_pool_max;
  assign w_emit = (r_state == S_REQ) & (r_pool_cnt == PW'(POOL_SIZE - 1));
  assign w_hold = r_out_valid & ~out_ready;
  assign w_accept = r_out_valid & out_ready;
  // a result waiting in OUT_WAIT sits in r_pool_max and moves out on the accept edge
  assign w_load_out = (w_emit & ~w_hold) | ((r_state == S_OUT_WAIT) & out_ready);
  assign w_base_nx = (addr_clr | (r_base_pend & w_load)) ? base_addr : r_base;
  assign w_idx_nx = addr_clr ? '0 : r_idx + ADDR_WIDTH'(w_accept);
  assign bias_rd_addr = ch_num;
  assign acc_ready = w_acc_ready;
  assign out_valid = r_out_valid;
  assign out_addr = r_out_addr;
  assign out_data = r_out_data;
  assign act_overflow = r_act_ovf;
  assign protocol_err = r_proto_err;
  always_comb begin
    w_next = r_state;
    w_acc_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_acc_ready = 1'b1;
        if (mac_en & start_p) w_next = last_p ? S_BIAS : S_ACCUM;
      end
      S_ACCUM: begin
        w_acc_ready = 1'b1;
        if (mac_en & last_p) w_next = S_BIAS;
      end
      S_BIAS: w_next = S_REQ;
      S_REQ: w_next = (w_emit & w_hold) ? S_OUT_WAIT : S_IDLE;
      S_OUT_WAIT: w_next = out_ready ? S_IDLE : S_OUT_WAIT;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_pool_max <= '0;
      r_pool_cnt <= '0;
      r_base <= '0;
      r_idx <= '0;
      r_base_pend <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data <= '0;
      r_out_addr <= '0;
      r_act_ovf <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_base <= w_base_nx;
      r_idx <= w_idx_nx;
      r_base_pend <= addr_clr | (r_base_pend & ~w_load);
      r_out_valid <= w_load_out | w_hold;
      if (w_load_out) begin
        r_out_data <= (r_state == S_REQ) ? w_pool : r_pool_max;
        r_out_addr <= w_base_nx + w_idx_nx;
      end
      if (r_state == S_REQ) r_pool_max <= w_pool;
      r_pool_cnt <= addr_clr ? '0 : (r_state != S_REQ) ? r_pool_cnt : w_emit ? '0 : r_pool_cnt + PW'(1);
      r_act_ovf <= ~addr_clr & (r_act_ovf | ((r_state == S_REQ) & w_clip));
      r_proto_err <= ~addr_clr & (r_proto_err | (mac_en & start_p & ~w_acc_ready));
    end
endmodule
